term_redirect_unit: RTL and testbench

- Front-end fetch-address sequencer and consumer of the terminate pipeline's result channel.
- Streams sequential 16-bit fetch addresses to instruction memory.
- Halts fetch when predecode reports a block terminator, then waits for the terminate pipeline to resolve it:
  - taken target (result_valid), or
  - not-taken (term_failed).
- Resumes at the target or the fall-through address, with a one-cycle flush pulse to downstream stages.

---
 rtl/term_redirect_unit_pkg.sv | 12 +
 rtl/term_redirect_unit_watchdog.sv | 27 ++
 rtl/term_redirect_unit.sv | 116 +++++++++++
 tb/tb_term_redirect_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/term_redirect_unit_pkg.sv
// rtl/term_redirect_unit_pkg.sv - shared fetch front-end types and constants
package term_redirect_unit_pkg;

    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0200;

    typedef enum logic {
        FETCH     = 1'b0,
        WAIT_TERM = 1'b1
    } fe_state_t;

endpackage

// File: rtl/term_redirect_unit_watchdog.sv
// rtl/term_redirect_unit_watchdog.sv - WAIT_TERM cycle counter, flags expiry after TIMEOUT_CYCLES waiting cycles
module term_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_wait,
    output logic expire
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (in_wait && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // fires on the edge that would complete the TIMEOUT_CYCLES-th waiting cycle
    assign expire = in_wait && (({1'b0, cnt} + 9'd1) >= LIMIT);

endmodule

// File: rtl/term_redirect_unit.sv
// rtl/term_redirect_unit.sv - fetch-address sequencer that halts on block terminators and redirects on resolution (option: TERM_TIMEOUT_EN)
module term_redirect_unit
    import term_redirect_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int FETCH_STRIDE = 1
`ifdef TERM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    input  logic              block_end,
    input  logic [ADDR_W-1:0] block_end_next,
    input  logic [ADDR_W-1:0] result_addr,
    input  logic              result_valid,
    output logic              result_ready,
    input  logic              term_failed,
    output logic              flush,
    output logic              waiting,
    output logic              timeout_err
);

    fe_state_t         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] fallthrough, fallthrough_n;
    logic              flush_q, flush_n;
    logic              wd_start;
    logic              wd_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            fallthrough <= '0;
            flush_q     <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fallthrough <= fallthrough_n;
            flush_q     <= flush_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        fallthrough_n = fallthrough;
        flush_n       = 1'b0;
        wd_start      = 1'b0;
        case (state)
            FETCH: begin
                if (fetch_ready) begin
                    pc_n = pc + ADDR_W'(FETCH_STRIDE);
                    if (block_end) begin
                        fallthrough_n = block_end_next;
                        state_n       = WAIT_TERM;
                        wd_start      = 1'b1;
                    end
                end
            end
            WAIT_TERM: begin
                // a taken target outranks a not-taken report or a watchdog expiry
                if (result_valid) begin
                    pc_n    = result_addr;
                    state_n = FETCH;
                    flush_n = 1'b1;
                end else if (term_failed || wd_expire) begin
                    pc_n    = fallthrough;
                    state_n = FETCH;
                    flush_n = 1'b1;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    assign fetch_addr   = pc;
    assign fetch_valid  = (state == FETCH);
    assign result_ready = (state == WAIT_TERM);
    assign waiting      = (state == WAIT_TERM);
    assign flush        = flush_q;

`ifdef TERM_TIMEOUT_EN
    logic err_q;

    term_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (wd_start),
        .in_wait (state == WAIT_TERM),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == WAIT_TERM && wd_expire && !result_valid && !term_failed) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_wd_start;
    assign unused_wd_start = wd_start;
    assign wd_expire       = 1'b0;
    assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_term_redirect_unit.sv
// tb/tb_term_redirect_unit.sv - table, sequence and random checks of term_redirect_unit (TERM_TIMEOUT_EN aware)
module tb_term_redirect_unit;

`ifdef TERM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TIMEOUT_LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        block_end;
    logic [15:0] block_end_next;
    logic [15:0] result_addr;
    logic        result_valid;
    logic        result_ready;
    logic        term_failed;
    logic        flush;
    logic        waiting;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    term_redirect_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .block_end      (block_end),
        .block_end_next (block_end_next),
        .result_addr    (result_addr),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .term_failed    (term_failed),
        .flush          (flush),
        .waiting        (waiting),
        .timeout_err    (timeout_err)
    );

    // reference: "waiting for a terminator" flag plus the address fetch will resume at
    bit          m_wait;
    logic [15:0] m_pc;
    logic [15:0] m_ft;
    bit          m_flush;
    bit          m_err;
    int          m_wcnt;

    task automatic model_edge();
        if (rst) begin
            m_wait = 0; m_pc = 16'h0200; m_flush = 0; m_err = 0; m_wcnt = 0;
            return;
        end
        m_flush = 0;
        if (!m_wait) begin
            if (fetch_ready) begin
                if (block_end) begin
                    m_ft = block_end_next; m_wait = 1; m_wcnt = 0;
                end else begin
                    m_pc = 16'((int'(m_pc) + 1) % 65536);
                end
            end
        end else if (result_valid) begin
            m_pc = result_addr; m_wait = 0; m_flush = 1;
        end else if (term_failed) begin
            m_pc = m_ft; m_wait = 0; m_flush = 1;
        end else begin
            m_wcnt++;
            if (TIMEOUT_EN && m_wcnt >= TIMEOUT_LIMIT) begin
                m_pc = m_ft; m_wait = 0; m_flush = 1; m_err = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; fetch_ready = 0; block_end = 0; block_end_next = '0;
        result_valid = 0; result_addr = '0; term_failed = 0;
    endtask

    task automatic chk_model(input string tag);
        if (m_wait == 0) chk({tag, " addr"}, 32'(fetch_addr), 32'(m_pc));
        chk({tag, " valid"}, 32'(fetch_valid), 32'(!m_wait));
        chk({tag, " waiting"}, 32'(waiting), 32'(m_wait));
        chk({tag, " result_ready"}, 32'(result_ready), 32'(m_wait));
        chk({tag, " flush"}, 32'(flush), 32'(m_flush));
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'(m_err));
    endtask

    typedef struct {
        logic        rst, fr, be;
        logic [15:0] ben;
        logic        rv;
        logic [15:0] ra;
        logic        tf;
        logic        ca;
        logic [15:0] ea;
        logic        ev, ef, ew;
    } vec_t;

    function automatic vec_t mk(logic r, logic fr, logic be, logic [15:0] ben, logic rv, logic [15:0] ra,
                                logic tf, logic ca, logic [15:0] ea, logic ev, logic ef, logic ew);
        vec_t v;
        v.rst = r; v.fr = fr; v.be = be; v.ben = ben; v.rv = rv; v.ra = ra; v.tf = tf;
        v.ca = ca; v.ea = ea; v.ev = ev; v.ef = ef; v.ew = ew;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        chk("reset addr", 32'(fetch_addr), 32'h0200);
        chk("reset valid", 32'(fetch_valid), 32'd1);
        chk("reset flush", 32'(flush), 32'd0);
        chk("reset result_ready", 32'(result_ready), 32'd0);
        chk("reset waiting", 32'(waiting), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);

        //            rst fr be ben       rv ra        tf ca ea       ev ef ew
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0201, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0202, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0202, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0212, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1234, 0, 1, 16'h1234, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1234, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1234, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0300, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h4000, 1, 1, 16'h4000, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0212, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0212, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h5555, 0, 1, 16'h0213, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0999, 0, 16'h0000, 0, 1, 16'h0213, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'hAAAA, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0200, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 16'hFFFF, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; fetch_ready = tbl[i].fr; block_end = tbl[i].be;
            block_end_next = tbl[i].ben; result_valid = tbl[i].rv; result_addr = tbl[i].ra;
            term_failed = tbl[i].tf;
            step();
            if (tbl[i].ca) chk($sformatf("row%0d addr", i), 32'(fetch_addr), 32'(tbl[i].ea));
            chk($sformatf("row%0d valid", i), 32'(fetch_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d flush", i), 32'(flush), 32'(tbl[i].ef));
            chk($sformatf("row%0d waiting", i), 32'(waiting), 32'(tbl[i].ew));
            chk($sformatf("row%0d result_ready", i), 32'(result_ready), 32'(tbl[i].ew));
        end

        // randomized traffic against the reference
        idle_inputs();
        rst = 1;
        step();
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            block_end      = ($urandom_range(0, 4) == 0);
            block_end_next = 16'($urandom);
            result_valid   = ($urandom_range(0, 5) == 0);
            result_addr    = 16'($urandom);
            term_failed    = ($urandom_range(0, 5) == 0);
            step();
            chk_model($sformatf("rand%0d", n));
        end

        // long wait with no resolution
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        fetch_ready = 1; block_end = 1; block_end_next = 16'h0300;
        step();
        idle_inputs();
        for (int k = 1; k < TIMEOUT_LIMIT; k++) begin
            step();
            chk($sformatf("wait%0d waiting", k), 32'(waiting), 32'd1);
        end
        step();
        if (TIMEOUT_EN) begin
            chk("timeout addr", 32'(fetch_addr), 32'h0300);
            chk("timeout valid", 32'(fetch_valid), 32'd1);
            chk("timeout flush", 32'(flush), 32'd1);
            chk("timeout err", 32'(timeout_err), 32'd1);
            for (int k = 0; k < 10; k++) step();
            chk("timeout err sticky", 32'(timeout_err), 32'd1);
            chk("timeout flush once", 32'(flush), 32'd0);
            rst = 1;
            step();
            rst = 0;
            chk("timeout err cleared", 32'(timeout_err), 32'd0);
            fetch_ready = 1; block_end = 1; block_end_next = 16'h0300;
            step();
            idle_inputs();
            for (int k = 1; k < TIMEOUT_LIMIT; k++) step();
            result_valid = 1; result_addr = 16'h7777;
            step();
            chk("race addr", 32'(fetch_addr), 32'h7777);
            chk("race err", 32'(timeout_err), 32'd0);
        end else begin
            for (int k = 0; k < 40; k++) step();
            chk("no-wd waiting", 32'(waiting), 32'd1);
            chk("no-wd err", 32'(timeout_err), 32'd0);
            term_failed = 1;
            step();
            chk("no-wd resume addr", 32'(fetch_addr), 32'h0300);
            chk("no-wd resume flush", 32'(flush), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
